btb_port_arbiter: RTL and testbench

// - Sole owner of the single-port 64x64 BHT/BTB RAM.
// - Shares the RAM between two requesters:
//   - fetch-stage lookups: 1-cycle read, returns hit / predicted-taken / target.
//   - execute-stage branch-outcome updates: 2-cycle read-modify-write (RMW).
// - Updates are buffered in a small FIFO. Fetch has priority, bounded by a starvation limit so updates always drain.

---
 rtl/btb_port_arbiter_if.sv | 50 +++++
 rtl/btb_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_btb_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_port_arbiter_if.sv
// Lookup, update, RAM and statistics signals of the BHT/BTB port arbiter.
interface btb_port_arbiter_if #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 24
);
    logic             lk_valid;
    logic             lk_ready;
    logic [IDX_W-1:0] lk_index;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_resp_valid;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_target;

    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      upd_target;
    logic             upd_taken;

    logic [IDX_W-1:0] ram_addr;
    logic             ram_wr_en;
    logic [63:0]      ram_wr_data;
    logic [63:0]      ram_rd_data;

    logic [15:0]      stat_hit;
    logic [15:0]      stat_miss;
    logic [15:0]      stat_stall;

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        input  upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        input  ram_rd_data,
        output lk_ready, lk_resp_valid, lk_hit, lk_taken, lk_target,
        output upd_ready,
        output ram_addr, ram_wr_en, ram_wr_data,
        output stat_hit, stat_miss, stat_stall
    );

    modport master (
        output lk_valid, lk_index, lk_tag,
        output upd_valid, upd_index, upd_tag, upd_target, upd_taken,
        output ram_rd_data,
        input  lk_ready, lk_resp_valid, lk_hit, lk_taken, lk_target,
        input  upd_ready,
        input  ram_addr, ram_wr_en, ram_wr_data,
        input  stat_hit, stat_miss, stat_stall
    );
endinterface

// File: rtl/btb_port_arbiter.sv
// Single-port BHT/BTB RAM owner: fetch lookups (1 cycle) share the port with
// queued branch-outcome read-modify-writes (2 cycles), fetch-first with a
// starvation bound. Optional statistics counters: define BTB_ARB_STATS_EN.
module btb_port_arbiter #(
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned TAG_W        = 24,
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    btb_port_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, UPD_WR} state_e;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             taken;
    } upd_t;

    state_e           state_q, state_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    upd_t             fifo_q [QDEPTH];
    upd_t             fifo_d [QDEPTH];

    upd_t             head, push_entry;
    logic             qne, full, force_upd, lk_ready_c, lk_accept, push, pop;
    logic             entry_hit, lk_hit_c;
    logic [1:0]       cnt_cur, cnt_nxt;
    logic [IDX_W-1:0] ram_addr_c;
    logic             ram_wr_en_c;
    logic [63:0]      ram_wr_data_c;
    logic             unused_rd;

    assign qne        = (count_q != '0);
    assign full       = (count_q == CNT_W'(QDEPTH));
    assign force_upd  = qne && (starve_q == SC_W'(STARVE_LIMIT));
    assign lk_ready_c = !reset && (state_q == IDLE) && !force_upd;
    assign lk_accept  = bus.lk_valid && lk_ready_c;
    assign push       = bus.upd_valid && !full;
    assign head       = fifo_q[rd_ptr_q];
    assign push_entry = {bus.upd_index, bus.upd_tag, bus.upd_target, bus.upd_taken};
    assign cnt_cur    = bus.ram_rd_data[58:57];
    assign entry_hit  = bus.ram_rd_data[56] && (bus.ram_rd_data[32 +: TAG_W] == head.tag);
    assign lk_hit_c   = resp_valid_q && bus.ram_rd_data[56] &&
                        (bus.ram_rd_data[32 +: TAG_W] == tag_q);
    assign unused_rd  = &{1'b0, bus.ram_rd_data[63:59]};

    // Saturating 2-bit direction counter update
    always_comb begin
        cnt_nxt = cnt_cur;
        if (head.taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
    end

    // Port arbitration, RMW sequencing and starvation tracking
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        resp_valid_d  = 1'b0;
        tag_d         = tag_q;
        pop           = 1'b0;
        ram_addr_c    = '0;
        ram_wr_en_c   = 1'b0;
        ram_wr_data_c = '0;
        case (state_q)
            IDLE: begin
                if (lk_accept) begin
                    ram_addr_c   = bus.lk_index;
                    resp_valid_d = 1'b1;
                    tag_d        = bus.lk_tag;
                    if (qne && (starve_q != SC_W'(STARVE_LIMIT)))
                        starve_d = starve_q + SC_W'(1);
                end else if (qne) begin
                    ram_addr_c = head.index;
                    state_d    = UPD_WR;
                    starve_d   = '0;
                end
            end
            UPD_WR: begin
                ram_addr_c                 = head.index;
                pop                        = 1'b1;
                state_d                    = IDLE;
                ram_wr_data_c[31:0]        = head.target;
                ram_wr_data_c[32 +: TAG_W] = head.tag;
                ram_wr_data_c[56]          = 1'b1;
                if (entry_hit) begin
                    ram_wr_en_c          = 1'b1;
                    ram_wr_data_c[58:57] = cnt_nxt;
                end else if (head.taken) begin
                    ram_wr_en_c          = 1'b1;
                    ram_wr_data_c[58:57] = 2'b10;
                end else begin
                    ram_wr_data_c = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!qne) starve_d = '0;
    end

    // Update FIFO pointers and storage
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            resp_valid_q <= 1'b0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            resp_valid_q <= resp_valid_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.lk_ready      = lk_ready_c;
    assign bus.lk_resp_valid = resp_valid_q;
    assign bus.lk_hit        = lk_hit_c;
    assign bus.lk_taken      = lk_hit_c && bus.ram_rd_data[58];
    assign bus.lk_target     = lk_hit_c ? bus.ram_rd_data[31:0] : 32'h0;
    assign bus.upd_ready     = !full;
    assign bus.ram_addr      = ram_addr_c;
    assign bus.ram_wr_en     = ram_wr_en_c;
    assign bus.ram_wr_data   = ram_wr_data_c;

`ifdef BTB_ARB_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating lookup hit/miss and stall counters
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (lk_hit_c && (hit_cnt_q != 16'hFFFF))
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (resp_valid_q && !lk_hit_c && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
        if (bus.lk_valid && !lk_ready_c && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stat_hit   = hit_cnt_q;
    assign bus.stat_miss  = miss_cnt_q;
    assign bus.stat_stall = stall_cnt_q;
`else
    assign bus.stat_hit   = 16'h0;
    assign bus.stat_miss  = 16'h0;
    assign bus.stat_stall = 16'h0;
`endif
endmodule

// File: tb/tb_btb_port_arbiter.sv
// Bench for btb_port_arbiter: RAM model, abstract BTB/queue reference model,
// directed scenarios followed by randomized traffic.
module tb_btb_port_arbiter;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned TAG_W        = 24;
    localparam int unsigned QDEPTH       = 4;
    localparam int unsigned STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    btb_port_arbiter_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

    btb_port_arbiter #(
        .IDX_W(IDX_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Synchronous-read single-port RAM, cleared by reset
    logic [63:0] ram [64];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 64'h0;
            bus.ram_rd_data <= 64'h0;
        end else begin
            bus.ram_rd_data <= ram[bus.ram_addr];
            if (bus.ram_wr_en) ram[bus.ram_addr] <= bus.ram_wr_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: BTB content as fields, pending updates as a queue
    typedef struct {
        bit [5:0]  idx;
        bit [23:0] tag;
        bit [31:0] tgt;
        bit        taken;
    } upd_s;

    upd_s      q[$];
    bit        m_valid [64];
    bit [23:0] m_tag   [64];
    bit [31:0] m_tgt   [64];
    int        m_cnt   [64];
    bit        m_rmw, m_pend;
    bit [5:0]  m_pidx;
    bit [23:0] m_ptag;
    int        m_starve, m_hits, m_miss, m_stall;

    bit        s_ready, s_upd_ready, s_rv, s_hit, s_taken, s_wr_en, s_lk_acc, s_upd_acc;
    bit [31:0] s_tgt;
    bit [63:0] s_wd;
    bit [15:0] s_stall;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
        m_rmw = 0; m_pend = 0; m_pidx = 0; m_ptag = 0;
        m_starve = 0; m_hits = 0; m_miss = 0; m_stall = 0;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Compare one cycle of DUT outputs with the model, then advance the model
    task automatic model_cycle();
        int        sz = q.size();
        bit        e_ready = !m_rmw && !(sz != 0 && m_starve == STARVE_LIMIT);
        bit        e_hit = 0, e_taken = 0, e_wr = 0, acc;
        bit [31:0] e_tgt = 0;
        bit [63:0] e_wd = 0;
        int        newcnt = 0;
        int        e_addr;
        upd_s      h;

        s_ready = bus.lk_ready; s_upd_ready = bus.upd_ready; s_rv = bus.lk_resp_valid;
        s_hit = bus.lk_hit; s_taken = bus.lk_taken; s_tgt = bus.lk_target;
        s_wr_en = bus.ram_wr_en; s_wd = bus.ram_wr_data; s_stall = bus.stat_stall;
        s_lk_acc = bus.lk_valid && bus.lk_ready;
        s_upd_acc = bus.upd_valid && bus.upd_ready;

        if (m_pend && m_valid[m_pidx] && m_tag[m_pidx] == m_ptag) begin
            e_hit = 1; e_taken = (m_cnt[m_pidx] >= 2); e_tgt = m_tgt[m_pidx];
        end
        check_eq("lk_ready", 64'(bus.lk_ready), 64'(e_ready));
        check_eq("upd_ready", 64'(bus.upd_ready), 64'(sz < QDEPTH));
        check_eq("resp_valid", 64'(bus.lk_resp_valid), 64'(m_pend));
        check_eq("lk_hit", 64'(bus.lk_hit), 64'(e_hit));
        check_eq("lk_taken", 64'(bus.lk_taken), 64'(e_taken));
        check_eq("lk_target", 64'(bus.lk_target), 64'(e_tgt));
        acc = bus.lk_valid && e_ready;

        if (m_rmw) begin
            h = q[0];
            if (m_valid[h.idx] && m_tag[h.idx] == h.tag) begin
                e_wr = 1;
                newcnt = h.taken ? ((m_cnt[h.idx] == 3) ? 3 : m_cnt[h.idx] + 1)
                                 : ((m_cnt[h.idx] == 0) ? 0 : m_cnt[h.idx] - 1);
            end else if (h.taken) begin
                e_wr = 1; newcnt = 2;
            end
            check_eq("wr_en", 64'(bus.ram_wr_en), 64'(e_wr));
            if (e_wr) begin
                e_wd = {5'b0, 2'(newcnt), 1'b1, h.tag, h.tgt};
                check_eq("wr_data", bus.ram_wr_data, e_wd);
                check_eq("wr_addr", 64'(bus.ram_addr), 64'(h.idx));
                m_valid[h.idx] = 1; m_tag[h.idx] = h.tag; m_tgt[h.idx] = h.tgt;
                m_cnt[h.idx] = newcnt;
            end
        end else begin
            check_eq("wr_en_idle", 64'(bus.ram_wr_en), 64'h0);
            e_addr = acc ? int'(bus.lk_index) : ((sz != 0) ? int'(q[0].idx) : 0);
            check_eq("ram_addr", 64'(bus.ram_addr), 64'(e_addr));
        end

`ifdef BTB_ARB_STATS_EN
        check_eq("stat_hit", 64'(bus.stat_hit), 64'(m_hits));
        check_eq("stat_miss", 64'(bus.stat_miss), 64'(m_miss));
        check_eq("stat_stall", 64'(bus.stat_stall), 64'(m_stall));
`else
        check_eq("stat_off", 64'({bus.stat_hit, bus.stat_miss, bus.stat_stall}), 64'h0);
`endif
        if (e_hit) m_hits = sat16(m_hits + 1);
        else if (m_pend) m_miss = sat16(m_miss + 1);
        if (bus.lk_valid && !e_ready) m_stall = sat16(m_stall + 1);

        if (m_rmw) begin
            void'(q.pop_front());
            m_rmw = 0;
        end else if (acc) begin
            if (sz != 0 && m_starve < STARVE_LIMIT) m_starve++;
        end else if (sz != 0) begin
            m_rmw = 1; m_starve = 0;
        end
        if (sz == 0) m_starve = 0;
        m_pend = acc; m_pidx = bus.lk_index; m_ptag = bus.lk_tag;
        if (bus.upd_valid && sz < QDEPTH)
            q.push_back('{idx: bus.upd_index, tag: bus.upd_tag, tgt: bus.upd_target,
                          taken: bus.upd_taken});
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lk(input bit v, input bit [5:0] idx, input bit [23:0] tag);
        bus.lk_valid = v; bus.lk_index = idx; bus.lk_tag = tag;
    endtask

    task automatic drive_upd(input bit v, input bit [5:0] idx, input bit [23:0] tag,
                             input bit [31:0] tgt, input bit tk);
        bus.upd_valid = v; bus.upd_index = idx; bus.upd_tag = tag;
        bus.upd_target = tgt; bus.upd_taken = tk;
    endtask

    task automatic idle(input int n);
        drive_lk(0, 0, 0); drive_upd(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset away from the clock edge and check the reset-state outputs
    task automatic apply_reset();
        drive_lk(1, 6'd5, 24'hABCDEF); drive_upd(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_eq("rst_lk_ready", 64'(bus.lk_ready), 64'h0);
        check_eq("rst_upd_ready", 64'(bus.upd_ready), 64'h1);
        check_eq("rst_resp", 64'({bus.lk_resp_valid, bus.lk_hit, bus.lk_taken}), 64'h0);
        check_eq("rst_target", 64'(bus.lk_target), 64'h0);
        check_eq("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
        check_eq("rst_wr_en", 64'(bus.ram_wr_en), 64'h0);
        check_eq("rst_wr_data", bus.ram_wr_data, 64'h0);
        check_eq("rst_stats", 64'({bus.stat_hit, bus.stat_miss, bus.stat_stall}), 64'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        drive_lk(0, 0, 0);
    endtask

    // Present one update and hold it until accepted; reports first-cycle readiness
    task automatic push_hold(input bit lv, input bit [5:0] idx, input bit [23:0] tag,
                             input bit [31:0] tgt, input bit tk, output bit first_ready);
        int n = 0;
        bus.lk_valid = lv;
        drive_upd(1, idx, tag, tgt, tk);
        step();
        first_ready = s_upd_ready;
        while (!s_upd_acc && n < 64) begin
            step();
            n++;
        end
        check_eq("push_accept", 64'(s_upd_acc), 64'h1);
        drive_upd(0, 0, 0, 0, 0);
    endtask

    // Push one update into an idle arbiter and check the write two cycles later
    task automatic upd_check(input string tag, input bit [5:0] idx, input bit [23:0] utag,
                             input bit [31:0] tgt, input bit tk, input bit exp_wr,
                             input bit [63:0] exp_wd);
        bit fr;
        push_hold(0, idx, utag, tgt, tk, fr);
        step();
        step();
        check_eq({tag, "_wr_en"}, 64'(s_wr_en), 64'(exp_wr));
        if (exp_wr) check_eq({tag, "_wr_data"}, s_wd, exp_wd);
        step();
    endtask

    task automatic lookup(input bit [5:0] idx, input bit [23:0] tag);
        int n = 0;
        drive_lk(1, idx, tag);
        step();
        while (!s_lk_acc && n < 20) begin
            step();
            n++;
        end
        check_eq("lk_accept", 64'(s_lk_acc), 64'h1);
        drive_lk(0, 0, 0);
        step();
    endtask

    initial begin
        bit fr;
        bit pend;
        int acc_n, stall_n, n;
        drive_lk(0, 0, 0); drive_upd(0, 0, 0, 0, 0);
        model_reset();
        #2;
        apply_reset();

        // Cold lookup misses
        lookup(6'd5, 24'hABCDEF);
        check_eq("t1_rv", 64'(s_rv), 64'h1);
        check_eq("t1_hit", 64'({s_hit, s_taken}), 64'h0);
        check_eq("t1_target", 64'(s_tgt), 64'h0);

        // Allocation on miss & taken, then hit
        upd_check("t2", 6'd5, 24'hABCDEF, 32'h400, 1, 1, 64'h05ABCDEF_00000400);
        lookup(6'd5, 24'hABCDEF);
        check_eq("t2_hit", 64'({s_hit, s_taken}), 64'h3);
        check_eq("t2_target", 64'(s_tgt), 64'h400);

        // Counter saturation both ways
        upd_check("t3a", 6'd5, 24'hABCDEF, 32'h400, 1, 1, 64'h07ABCDEF_00000400);
        upd_check("t3b", 6'd5, 24'hABCDEF, 32'h400, 1, 1, 64'h07ABCDEF_00000400);
        upd_check("t3c", 6'd5, 24'hABCDEF, 32'h400, 0, 1, 64'h05ABCDEF_00000400);
        upd_check("t3d", 6'd5, 24'hABCDEF, 32'h400, 0, 1, 64'h03ABCDEF_00000400);
        upd_check("t3e", 6'd5, 24'hABCDEF, 32'h400, 0, 1, 64'h01ABCDEF_00000400);
        upd_check("t3f", 6'd5, 24'hABCDEF, 32'h400, 0, 1, 64'h01ABCDEF_00000400);
        lookup(6'd5, 24'hABCDEF);
        check_eq("t3_hit", 64'({s_hit, s_taken}), 64'h2);

        // Starvation bound under continuous lookups
        apply_reset();
        drive_lk(1, 6'd3, 24'h7);
        drive_upd(1, 6'd30, 24'h55, 32'h1234, 1);
        step();
        drive_upd(0, 0, 0, 0, 0);
        acc_n = 0; n = 0;
        do begin step(); if (s_ready) acc_n++; n++; end while (s_ready && n < 30);
        stall_n = 1; n = 0;
        do begin step(); if (!s_ready) stall_n++; n++; end while (!s_ready && n < 10);
        check_eq("t4_accepts", 64'(acc_n), 64'd8);
        check_eq("t4_stalls", 64'(stall_n), 64'd2);
`ifdef BTB_ARB_STATS_EN
        check_eq("t4_stat_stall", 64'(s_stall), 64'd2);
`endif
        idle(4);

        // FIFO fill under lookup pressure; nothing lost
        for (int k = 0; k < 5; k++) begin
            push_hold(1, 6'(10 + k), 24'(24'h100 + k), 32'(32'h2000 + 4 * k), 1, fr);
            check_eq("t5_first_ready", 64'(fr), 64'(k < 4));
        end
        idle(20);
        for (int k = 0; k < 5; k++) begin
            lookup(6'(10 + k), 24'(24'h100 + k));
            check_eq("t5_hit", 64'(s_hit), 64'h1);
            check_eq("t5_target", 64'(s_tgt), 64'(32'h2000 + 4 * k));
        end

        // Miss & not-taken writes nothing; reset during the write cycle aborts it
        upd_check("t6a", 6'd9, 24'h999, 32'h900, 0, 0, 64'h0);
        drive_upd(1, 6'd20, 24'h20, 32'h2020, 1);
        step();
        drive_upd(1, 6'd21, 24'h21, 32'h2121, 1);
        step();
        drive_upd(0, 0, 0, 0, 0);
        check_eq("t6_pre_wr", 64'(bus.ram_wr_en), 64'h1);
        apply_reset();
        idle(4);
        lookup(6'd20, 24'h20);
        check_eq("t6_aborted", 64'(s_hit), 64'h0);
        lookup(6'd21, 24'h21);
        check_eq("t6_flushed", 64'(s_hit), 64'h0);

        // Randomized traffic
        pend = 0;
        for (int c = 0; c < 1500; c++) begin
            drive_lk($urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)),
                     24'($urandom_range(1, 2)));
            if (!pend && $urandom_range(0, 2) == 0) begin
                drive_upd(1, 6'($urandom_range(0, 7)), 24'($urandom_range(1, 2)),
                          32'($urandom), 1'($urandom_range(0, 1)));
                pend = 1;
            end
            step();
            if (s_upd_acc) begin
                pend = 0;
                bus.upd_valid = 0;
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
